// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub result FIFO: default geometry, the
// stored entry record, the occupancy state encoding and a saturating counter helper.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 4;
  localparam int ADDSUB_DEPTH = 4;

  // One stored adder/subtractor result, kept exactly as produced upstream.
  typedef struct packed {
    logic [ADDSUB_WIDTH-1:0] result;
    logic                    carry;
    logic                    overflow;
    logic                    mode;     // 0 = add, 1 = sub
  } addsub_entry_t;

  // Occupancy classes of the FIFO.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Increment an 8-bit counter by one when enabled, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value, input logic en);
    logic [7:0] res;
    if (en && (value != 8'hFF)) begin
      res = value + 8'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_fifo_mem.sv
// Entry storage for the add/sub result FIFO: DEPTH words of DW bits,
// one synchronous write port and one asynchronous read port. No reset:
// contents are only ever observed through the FIFO's read pointer.
module addsub_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 7
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write the pushed entry into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/addsub_result_fifo.sv
// Result FIFO sitting behind a WIDTH-bit adder/subtractor. Stores raw
// {result, carry, overflow, mode} entries in strict order, reports occupancy
// and keeps a sticky overflow flag. Defining ADDSUB_STATS_EN adds the
// saturating op_count / sub_count push statistics outputs.
module addsub_result_fifo
  import addsub_pkg::*;
#(
  parameter int DEPTH = ADDSUB_DEPTH,
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_overflow,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_overflow,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
`ifdef ADDSUB_STATS_EN
  output logic [7:0]               op_count,
  output logic [7:0]               sub_count,
`endif
  input  logic                     clear_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;

  // Same layout as addsub_entry_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             mode;
  } fifo_entry_t;

  // Control state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  occ_state_e    occ_q, occ_d;
  logic          in_ready_q, out_valid_q;
  logic          sticky_q, sticky_d;

  logic          push_s, pop_s;
  fifo_entry_t   wr_entry_s, rd_entry_s;
  logic [EW-1:0] rd_data_s;

`ifdef ADDSUB_STATS_EN
  logic [7:0]    op_count_q, op_count_d;
  logic [7:0]    sub_count_q, sub_count_d;
`endif

  // Handshake qualification: a full FIFO refuses pushes, an empty one has nothing to pop.
  always_comb begin
    push_s = in_valid && (occ_q != OCC_FULL);
    pop_s  = out_ready && (occ_q != OCC_EMPTY);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    sticky_d = sticky_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (count_d == CW'(0)) begin
      occ_d = OCC_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      occ_d = OCC_FULL;
    end else begin
      occ_d = OCC_PARTIAL;
    end

    // A new overflow wins over a clear in the same cycle.
    if (push_s && in_overflow) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

`ifdef ADDSUB_STATS_EN
  // Saturating push and subtraction counters.
  always_comb begin
    op_count_d  = sat_inc8(op_count_q, push_s);
    sub_count_d = sat_inc8(sub_count_q, push_s && in_mode);
  end
`endif

  // Occupancy state machine and registered flags; reset discards every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      occ_q       <= occ_d;
      in_ready_q  <= (occ_d != OCC_FULL);
      out_valid_q <= (occ_d != OCC_EMPTY);
      sticky_q    <= sticky_d;
    end
  end

`ifdef ADDSUB_STATS_EN
  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q  <= 8'd0;
      sub_count_q <= 8'd0;
    end else begin
      op_count_q  <= op_count_d;
      sub_count_q <= sub_count_d;
    end
  end

  assign op_count  = op_count_q;
  assign sub_count = sub_count_q;
`endif

  assign wr_entry_s = '{result: in_result, carry: in_carry, overflow: in_overflow, mode: in_mode};

  // Writes are suppressed during reset so a push in the reset cycle leaves no trace.
  addsub_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s && rst_n),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // The head slot cannot be overwritten while it is valid (full blocks pushes),
  // so these fields hold steady across a stalled consumer.
  assign rd_entry_s   = fifo_entry_t'(rd_data_s);
  assign out_result   = rd_entry_s.result;
  assign out_carry    = rd_entry_s.carry;
  assign out_overflow = rd_entry_s.overflow;
  assign out_mode     = rd_entry_s.mode;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign count        = count_q;
  assign sticky_ovf   = sticky_q;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Self-checking bench for addsub_result_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_addsub_result_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry, in_overflow, in_mode;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry, out_overflow, out_mode;
  logic [2:0]       count;
  logic             sticky_ovf;
  logic             clear_sticky;
`ifdef ADDSUB_STATS_EN
  logic [7:0]       op_count, sub_count;
`endif

  addsub_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_mode     (out_mode),
    .count        (count),
    .sticky_ovf   (sticky_ovf),
`ifdef ADDSUB_STATS_EN
    .op_count     (op_count),
    .sub_count    (sub_count),
`endif
    .clear_sticky (clear_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             m;
  } ent_t;

  ent_t q[$];
  bit   sticky_m;
  int   ops_m, subs_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rdy, input logic [WIDTH-1:0] res,
                       input logic c, input logic o, input logic m, input logic clr);
    in_valid     = v;
    out_ready    = rdy;
    in_result    = res;
    in_carry     = c;
    in_overflow  = o;
    in_mode      = m;
    clear_sticky = clr;
  endtask

  task automatic drive_rand(input logic v, input logic rdy);
    drive(v, rdy, WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // One clock: the model decides acceptance from its own occupancy, then the
  // DUT's visible state is compared against the model.
  task automatic tick();
    bit   push_m, pop_m;
    ent_t e;
    push_m = rst_n && in_valid && (q.size() < DEPTH);
    pop_m  = rst_n && out_ready && (q.size() > 0);
    e.r = in_result; e.c = in_carry; e.v = in_overflow; e.m = in_mode;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      sticky_m = 1'b0;
      ops_m    = 0;
      subs_m   = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(e);
        if (ops_m < 255) ops_m++;
        if (e.m && subs_m < 255) subs_m++;
      end
      if (push_m && e.v) sticky_m = 1'b1;
      else if (clear_sticky) sticky_m = 1'b0;
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("sticky_ovf", 32'(sticky_ovf), 32'(sticky_m));
    if (q.size() > 0) begin
      chk("head_result", 32'(out_result), 32'(q[0].r));
      chk("head_carry", 32'(out_carry), 32'(q[0].c));
      chk("head_overflow", 32'(out_overflow), 32'(q[0].v));
      chk("head_mode", 32'(out_mode), 32'(q[0].m));
    end
`ifdef ADDSUB_STATS_EN
    chk("op_count", 32'(op_count), 32'(ops_m));
    chk("sub_count", 32'(sub_count), 32'(subs_m));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sticky_m = 1'b0; ops_m = 0; subs_m = 0;

    // Power-on reset
    repeat (2) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Single entry: 3+2 = 5
    drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_result", 32'(out_result), 32'd5);
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("single_pop_count", 32'(count), 32'd0);

    // Fill: 3-2 = 1 (carry), then 7+1 = 8 (overflow) with a simultaneous clear
    drive(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("ovf_set_beats_clear", 32'(sticky_ovf), 32'd1);
    drive(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fifth_dropped", 32'(count), 32'd4);
    chk("fill_head_result", 32'(out_result), 32'd1);
    chk("fill_head_mode", 32'(out_mode), 32'd1);

    // Drain in push order
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drain2_result", 32'(out_result), 32'd8);
    chk("drain2_overflow", 32'(out_overflow), 32'd1);
    tick();
    chk("drain3_result", 32'(out_result), 32'd6);
    tick();
    chk("drain4_result", 32'(out_result), 32'd3);
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Clear alone drops the sticky flag
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sticky_cleared", 32'(sticky_ovf), 32'd0);

    // Concurrent push/pop at occupancy 2 across pointer wrap
    repeat (2) begin
      drive_rand(1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    chk("concurrent_count", 32'(count), 32'd2);

    // Random traffic, including stalls, ignored inputs and clears
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), WIDTH'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      tick();
    end

    // Reset in the middle of traffic
    repeat (3) begin
      drive(1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sticky", 32'(sticky_ovf), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("postrst_result", 32'(out_result), 32'd12);
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef ADDSUB_STATS_EN
    // Saturation: 300 pushes, 260 of them subtractions
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, WIDTH'($urandom), 1'($urandom), 1'b0, 1'(i < 260), 1'b0);
      tick();
    end
    chk("op_count_sat", 32'(op_count), 32'd255);
    chk("sub_count_sat", 32'(sub_count), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
